// File: rtl/router_pkt_tx_if.sv
// Command/back-pressure and byte-stream bundle of the router packet transmitter.
// The slave modport is the transmitter; the master modport is the side requesting packets.
interface router_pkt_tx_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [1:0]       dest_addr;
  logic [5:0]       pay_len;
  logic             mode;
  logic [7:0]       seed;
  logic             busy;
  logic [7:0]       data_out;
  logic             pkt_valid;
  logic             done;
  logic             err;
  logic             idle;
  logic [CNT_W-1:0] pkt_cnt;

  modport master (
    output start, dest_addr, pay_len, mode, seed, busy,
    input  data_out, pkt_valid, done, err, idle, pkt_cnt
  );

  modport slave (
    input  start, dest_addr, pay_len, mode, seed, busy,
    output data_out, pkt_valid, done, err, idle, pkt_cnt
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router test-packet generator: header {len, addr}, len payload bytes, even-parity byte.
// All outputs are registered; busy freezes the byte stream outside IDLE.
module router_pkt_tx #(
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StParity} state_e;

  state_e           state_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             done_q;
  logic             err_q;
  logic             idle_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       par_q;
  logic [5:0]       rem_q;
  logic [5:0]       len_q;
  logic [7:0]       pat_q;
  logic             mode_q;

  // pat_q always holds the next payload byte to be presented.
  function automatic logic [7:0] next_pat(input logic [7:0] cur, input logic lfsr);
    return lfsr ? {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]} : cur + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
      cnt_q   <= '0;
      par_q   <= 8'h00;
      rem_q   <= 6'd0;
      len_q   <= 6'd0;
      pat_q   <= 8'h00;
      mode_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.pay_len != 6'd0) begin
              len_q   <= bus.pay_len;
              mode_q  <= bus.mode;
              data_q  <= {bus.pay_len, bus.dest_addr};
              par_q   <= {bus.pay_len, bus.dest_addr};
              valid_q <= 1'b1;
              idle_q  <= 1'b0;
              // An all-zero LFSR would lock up, so seed 0 is replaced by 1.
              pat_q   <= (bus.mode && bus.seed == 8'h00) ? 8'h01 : bus.seed;
              state_q <= StHeader;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StHeader: begin
          if (!bus.busy) begin
            data_q  <= pat_q;
            pat_q   <= next_pat(pat_q, mode_q);
            rem_q   <= len_q;
            state_q <= StPayload;
          end
        end
        StPayload: begin
          if (!bus.busy) begin
            par_q <= par_q ^ data_q;
            rem_q <= rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              data_q  <= par_q ^ data_q;
              valid_q <= 1'b0;
              state_q <= StParity;
            end else begin
              data_q <= pat_q;
              pat_q  <= next_pat(pat_q, mode_q);
            end
          end
        end
        StParity: begin
          if (!bus.busy) begin
            data_q  <= 8'h00;
            idle_q  <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.pkt_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.idle      = idle_q;
  assign bus.pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: per-cycle vector table plus reset and long-packet sequences.
module tb_router_pkt_tx;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  router_pkt_tx_if #(.CNT_W(16)) dif ();

  router_pkt_tx #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [1:0]  addr;
    logic [5:0]  len;
    logic        mode;
    logic [7:0]  seed;
    logic        busy;
    logic [7:0]  e_data;
    logic        e_valid;
    logic        e_done;
    logic        e_err;
    logic        e_idle;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVec = 22;
  vec_t vecs[NVec];

  task automatic set_in(input logic st, input logic [1:0] a, input logic [5:0] l,
                        input logic m, input logic [7:0] s, input logic b);
    dif.start     = st;
    dif.dest_addr = a;
    dif.pay_len   = l;
    dif.mode      = m;
    dif.seed      = s;
    dif.busy      = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {4'h0, dif.data_out, dif.pkt_valid, dif.done, dif.err, dif.idle, dif.pkt_cnt};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [7:0] d, input logic v, input logic dn,
                                           input logic e, input logic i, input logic [15:0] c);
    return {4'h0, d, v, dn, e, i, c};
  endfunction

  function automatic vec_t mk(input logic st, input logic [1:0] a, input logic [5:0] l,
                              input logic m, input logic [7:0] s, input logic b,
                              input logic [7:0] d, input logic v, input logic dn,
                              input logic e, input logic i, input logic [15:0] c);
    vec_t r;
    r.start = st; r.addr = a; r.len = l; r.mode = m; r.seed = s; r.busy = b;
    r.e_data = d; r.e_valid = v; r.e_done = dn; r.e_err = e; r.e_idle = i; r.e_cnt = c;
    return r;
  endfunction

  logic [7:0] exp_b;
  logic [7:0] par;

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Row i: inputs held across one rising edge, then outputs expected after it.
    // Basic packet addr 2, len 3, seed 10.
    vecs[0]  = mk(1, 2, 3, 0, 8'h10, 0, 8'h0E, 1, 0, 0, 0, 16'd0);
    vecs[1]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h10, 1, 0, 0, 0, 16'd0);
    vecs[2]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h11, 1, 0, 0, 0, 16'd0);
    vecs[3]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h12, 1, 0, 0, 0, 16'd0);
    vecs[4]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h1D, 0, 0, 0, 0, 16'd0);
    vecs[5]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd1);
    // Back-to-back start on the done cycle, then 3 busy cycles on 11 and a stray start.
    vecs[6]  = mk(1, 2, 3, 0, 8'h10, 0, 8'h0E, 1, 0, 0, 0, 16'd1);
    vecs[7]  = mk(0, 0, 0, 1, 8'h55, 0, 8'h10, 1, 0, 0, 0, 16'd1);
    vecs[8]  = mk(1, 1, 5, 1, 8'h77, 0, 8'h11, 1, 0, 0, 0, 16'd1);
    vecs[9]  = mk(1, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0, 0, 16'd1);
    vecs[10] = mk(0, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0, 0, 16'd1);
    vecs[11] = mk(0, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0, 0, 16'd1);
    vecs[12] = mk(0, 0, 0, 0, 8'h00, 0, 8'h12, 1, 0, 0, 0, 16'd1);
    vecs[13] = mk(0, 0, 0, 0, 8'h00, 0, 8'h1D, 0, 0, 0, 0, 16'd1);
    vecs[14] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd2);
    // Zero-length start: err only, busy ignored in IDLE.
    vecs[15] = mk(1, 1, 0, 0, 8'h33, 1, 8'h00, 0, 0, 1, 1, 16'd2);
    vecs[16] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 16'd2);
    // LFSR, seed 0 -> P0 = 01; mode/seed changes after start must not matter.
    vecs[17] = mk(1, 0, 2, 1, 8'h00, 1, 8'h08, 1, 0, 0, 0, 16'd2);
    vecs[18] = mk(0, 3, 9, 0, 8'hFF, 0, 8'h01, 1, 0, 0, 0, 16'd2);
    vecs[19] = mk(0, 0, 0, 0, 8'h00, 0, 8'h02, 1, 0, 0, 0, 16'd2);
    vecs[20] = mk(0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 0, 0, 16'd2);
    vecs[21] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd3);

    set_in(0, 0, 0, 0, 8'h00, 0);
    rst = 1'b1;
    #2;
    check("reset", obs(), pack_exp(8'h00, 0, 0, 0, 1, 16'd0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      set_in(vecs[i].start, vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].seed,
             vecs[i].busy);
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(),
            pack_exp(vecs[i].e_data, vecs[i].e_valid, vecs[i].e_done, vecs[i].e_err,
                     vecs[i].e_idle, vecs[i].e_cnt));
    end

    // Asynchronous reset in the middle of the payload.
    set_in(1, 1, 4, 0, 8'h20, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    @(negedge clk);
    check("mid pre-reset", obs(), pack_exp(8'h21, 1, 0, 0, 0, 16'd3));
    #2 rst = 1'b1;
    #1;
    check("mid async reset", obs(), pack_exp(8'h00, 0, 0, 0, 1, 16'd0));
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 1, 1, 0, 8'hAA, 0);
    @(negedge clk);
    check("post-rst hdr", obs(), pack_exp(8'h05, 1, 0, 0, 0, 16'd0));
    set_in(0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    check("post-rst P0", obs(), pack_exp(8'hAA, 1, 0, 0, 0, 16'd0));
    @(negedge clk);
    check("post-rst parity", obs(), pack_exp(8'hAF, 0, 0, 0, 0, 16'd0));
    @(negedge clk);
    check("post-rst done", obs(), pack_exp(8'h00, 0, 1, 0, 1, 16'd1));

    // Longest packet, incrementing from F0 so the payload wraps FF -> 00.
    set_in(1, 0, 63, 0, 8'hF0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 8'h00, 0);
    check("l63 hdr", obs(), pack_exp(8'hFC, 1, 0, 0, 0, 16'd1));
    par = 8'hFC;
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      exp_b = 8'hF0 + 8'(k);
      par   = par ^ exp_b;
      check($sformatf("l63 P%0d", k), obs(), pack_exp(exp_b, 1, 0, 0, 0, 16'd1));
    end
    @(negedge clk);
    check("l63 parity", obs(), pack_exp(par, 0, 0, 0, 0, 16'd1));
    @(negedge clk);
    check("l63 done", obs(), pack_exp(8'h00, 0, 1, 0, 1, 16'd2));
    @(negedge clk);
    check("l63 done pulse", obs(), pack_exp(8'h00, 0, 0, 0, 1, 16'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet transmitter (test-packet generator) for the router input port.
- Builds router-protocol packets: header byte {len[5:0], addr[1:0]}, then len payload bytes, then one even-parity byte.
- Honours the router's busy back-pressure.
- It is the sending end of the packet format that the router's output FIFOs store and later decode (header flag, length in header bits [7:2]).

Parameters:
- CNT_W, 16, width of the sent-packet counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one packet; sampled only in IDLE.
- dest_addr  in  2  destination port, 0..2 (3 passed through unchecked).
- pay_len  in  6  payload length in bytes, 1..63.
- mode  in  1  payload pattern: 0 = incrementing, 1 = LFSR.
- seed  in  8  first payload byte / LFSR seed.
- busy  in  1  router back-pressure; 1 = do not advance.
- data_out  out  8  byte presented to the router.
- pkt_valid  out  1  high while header and payload are driven; low on the parity byte.
- done  out  1  one-cycle pulse after the parity byte is accepted.
- err  out  1  one-cycle pulse when start arrives with pay_len == 0.
- idle  out  1  high in IDLE.
- pkt_cnt  out  CNT_W  packets completed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst = 1), all registered:
  - state = IDLE; data_out = 0; pkt_valid = 0; done = 0; err = 0; idle = 1; pkt_cnt = 0; internal parity, remaining-count and pattern registers = 0.
  - Reset mid-packet abandons the packet immediately; no done pulse.
- States: IDLE, HEADER, PAYLOAD, PARITY.
- Transfer rule: in HEADER, PAYLOAD or PARITY, the byte on data_out is accepted at a rising edge where busy == 0. With busy == 1, data_out, pkt_valid and state hold unchanged, for any number of cycles.
- IDLE:
  - start = 1 and pay_len != 0: latch addr and len; next cycle data_out = {pay_len, dest_addr}, pkt_valid = 1, idle = 0; parity = header; go to HEADER.
  - start = 1 and pay_len == 0: err = 1 for one cycle; stay in IDLE.
  - busy is ignored in IDLE.
- HEADER, on transfer: data_out = first payload byte P0; remaining = len; go to PAYLOAD.
- PAYLOAD, on transfer:
  - parity ^= data_out; remaining -= 1.
  - If remaining was 1: data_out = parity ^ data_out (the final parity), pkt_valid = 0, go to PARITY.
  - Otherwise: data_out = next pattern byte.
- PARITY, on transfer: go to IDLE; data_out = 0; idle = 1; done = 1 for one cycle; pkt_cnt += 1.
- Earliest next start: the cycle done is high. That start is sampled and accepted, so back-to-back packets have a gap of exactly one cycle.
- Payload pattern:
  - mode 0: Pk = (seed + k) mod 256.
  - mode 1: P0 = seed, or 8'h01 if seed == 0. Next byte = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
  - mode and seed are latched at start; changes mid-packet have no effect.
- Parity = XOR of header and all payload bytes.
- start outside IDLE is ignored; err is not raised.
- Inputs latched at start; dest_addr and pay_len may change freely afterwards.
- Minimum packet with busy held low: 1 + len + 1 data cycles.

Test Plan:
- Basic packet: addr = 2, len = 3, mode 0, seed = 8'h10, busy = 0. Required:
  - data_out sequence 0E, 10, 11, 12, 1D on consecutive cycles.
  - pkt_valid high for the first four bytes, low on 1D.
  - done pulse on the following cycle; pkt_cnt = 1.
- Back-pressure: same packet, busy = 1 for 3 cycles while 8'h11 is on data_out. Required:
  - 8'h11 and pkt_valid = 1 held for exactly 3 extra cycles.
  - Resulting sequence and parity 1D unchanged.
- LFSR: addr = 0, len = 2, mode 1, seed = 8'h00. Required: bytes 08, 01, 02, then parity 0B.
- Error and ignore:
  - start with pay_len = 0 -> err pulse only; idle stays 1, pkt_valid stays 0.
  - start asserted during PAYLOAD -> no effect on the sequence.
- Reset mid-packet: assert rst between clock edges during PAYLOAD. Required:
  - All outputs go to reset values immediately, with no clock edge needed.
  - After release, a new start yields a correct complete packet; pkt_cnt = 1, counting from 0.
- Boundaries:
  - len = 63 in mode 0 with seed = 8'hF0: payload wraps FF -> 00; 65 byte cycles total.
  - Back-to-back start on the done cycle: next header appears exactly one cycle after done.
